// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle RV32 control unit:
//   - state_e   : 16 controller states, 4-bit encoding
//   - opcode    : RV32 major opcodes recognised by DECODE
//   - select encodings for wb_sel / alu_op / alu_src_a / alu_src_b / pc_source
//   - ctrl_t    : bundle of every datapath control strobe/select
//   - is_wait_state() : states that wait on mem_ready
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_EXEC_R  = 4'd7,
        S_EXEC_I  = 4'd8,
        S_ALU_WB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JAL     = 4'd11,
        S_JALR    = 4'd12,
        S_LUI     = 4'd13,
        S_HALT    = 4'd14,
        S_ERROR   = 4'd15
    } state_e;

    // RV32 major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Write-back source
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RFUNC = 2'b10;
    localparam logic [1:0] ALU_IFUNC = 2'b11;

    // ALU operand A
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU operand B
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Next-PC source
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JALR   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_inv;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that sit waiting for the memory handshake
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// ----------------------------------------------------------------------------
// mc_ctrl_outdec
// Purely combinational output decoder: maps the current controller state
// (plus mem_ready and funct3[0]) onto the full datapath control vector.
// Any field not set for a state stays 0, so RESET/HALT/ERROR issue nothing.
// Ports:
//   i_state      in   state_e  current controller state
//   i_mem_ready  in   1        memory handshake (gates IR/PC update in FETCH)
//   i_funct3_lsb in   1        funct3[0] of IR (BEQ=0 / BNE=1)
//   o_ctrl       out  ctrl_t   control strobes and mux selects
// ----------------------------------------------------------------------------
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    input  logic   i_funct3_lsb,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (i_state)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed
                // together with the IR on the completing cycle.
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCS_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Speculative branch/jump target: ALUOut = oldPC + imm
                o_ctrl.alu_src_a = SRCA_OLDPC;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADR: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wb_sel    = WB_MDR;
            end
            S_MEM_WR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_RS2;
                o_ctrl.alu_op    = ALU_RFUNC;
            end
            S_EXEC_I: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_IFUNC;
            end
            S_ALU_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wb_sel    = WB_ALUOUT;
            end
            S_BRANCH: begin
                // Compare rs1-rs2; target already in ALUOut from DECODE.
                // branch_inv flips the zero test for BNE.
                o_ctrl.alu_src_a     = SRCA_RS1;
                o_ctrl.alu_src_b     = SRCB_RS2;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCS_ALUOUT;
                o_ctrl.branch_inv    = i_funct3_lsb;
            end
            S_JAL: begin
                // rd <= PC (already PC+4) on the same edge PC takes the target
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_ALUOUT;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wb_sel    = WB_PC;
            end
            S_JALR: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_JALR;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wb_sel    = WB_PC;
            end
            S_LUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wb_sel    = WB_IMM;
            end
            default: begin
                // RESET, HALT, ERROR: everything idle
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// FSM control unit for the multi-cycle RV32 datapath. Holds the state
// register, the memory wait counter (timeout) and the sticky error flags;
// all control outputs are decoded combinationally from the state by
// mc_ctrl_outdec, so an asynchronous reset drops every strobe immediately.
//
// Optional feature macro: MC_CTRL_PERF_EN adds cycle_cnt / instret_cnt.
//
// Parameters:
//   MEM_TIMEOUT  consecutive mem_ready=0 cycles tolerated per access (0 = off)
//   CNT_W        perf counter width
// Ports:
//   clk, rst_n              clock / async active-low reset
//   instr[31:0]             IR contents
//   mem_ready               memory completes current access this cycle
//   halt_req                park at next instruction boundary
//   pc_write .. reg_write   1-bit strobes
//   wb_sel, alu_op, alu_src_a, alu_src_b, pc_source   2-bit selects
//   state[3:0]              current state_e
//   halted, err_illegal, err_timeout   status
//   cycle_cnt, instret_cnt  (MC_CTRL_PERF_EN only)
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_inv,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        halted,
    output logic        err_illegal,
    output logic        err_timeout
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    // Counter just wide enough to hold MEM_TIMEOUT-1 (1 bit when disabled)
    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err_illegal;
    logic              r_err_timeout;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_waiting;
    logic              w_timeout;
    ctrl_t             w_ctrl;
    logic              w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_funct3       = instr[14:12];
    assign w_unused_instr = ^{instr[31:15], instr[11:7]};

    assign w_waiting = is_wait_state(r_state);
    // The final tolerated stall cycle expires only if memory is still not
    // ready; a completing handshake on that cycle takes priority.
    assign w_timeout = (MEM_TIMEOUT > 0) && !mem_ready && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RESET;
            r_wait_cnt    <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            // Any cycle that is not a stalled wait (including every state
            // entry) leaves the counter at zero.
            r_wait_cnt <= (w_waiting && !mem_ready) ? r_wait_cnt + 1'b1 : '0;

            case (r_state)
                S_RESET: r_state <= halt_req ? S_HALT : S_FETCH;

                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state       <= S_ERROR;
                        r_err_timeout <= 1'b1;
                    end
                end

                S_DECODE: begin
                    case (w_opcode)
                        OP_LOAD, OP_STORE: r_state <= S_MEM_ADR;
                        OP_R:              r_state <= S_EXEC_R;
                        OP_I:              r_state <= S_EXEC_I;
                        OP_JAL:            r_state <= S_JAL;
                        OP_JALR:           r_state <= S_JALR;
                        OP_LUI:            r_state <= S_LUI;
                        OP_BRANCH: begin
                            // Only BEQ/BNE are implemented
                            if (w_funct3[2:1] == 2'b00) begin
                                r_state <= S_BRANCH;
                            end else begin
                                r_state       <= S_ERROR;
                                r_err_illegal <= 1'b1;
                            end
                        end
                        default: begin
                            r_state       <= S_ERROR;
                            r_err_illegal <= 1'b1;
                        end
                    endcase
                end

                S_MEM_ADR: r_state <= (w_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;

                S_MEM_RD: begin
                    if (mem_ready) begin
                        r_state <= S_MEM_WB;
                    end else if (w_timeout) begin
                        r_state       <= S_ERROR;
                        r_err_timeout <= 1'b1;
                    end
                end

                S_MEM_WR: begin
                    // The store retires on the handshake cycle itself
                    if (mem_ready) begin
                        r_state <= halt_req ? S_HALT : S_FETCH;
                    end else if (w_timeout) begin
                        r_state       <= S_ERROR;
                        r_err_timeout <= 1'b1;
                    end
                end

                S_EXEC_R, S_EXEC_I: r_state <= S_ALU_WB;

                S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI:
                    r_state <= halt_req ? S_HALT : S_FETCH;

                S_HALT: begin
                    if (!halt_req) begin
                        r_state <= S_FETCH;
                    end
                end

                S_ERROR: r_state <= S_ERROR;

                default: r_state <= S_ERROR;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .i_state      (r_state),
        .i_mem_ready  (mem_ready),
        .i_funct3_lsb (w_funct3[0]),
        .o_ctrl       (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign branch_inv    = w_ctrl.branch_inv;
    assign iord          = w_ctrl.iord;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_write     = w_ctrl.reg_write;
    assign wb_sel        = w_ctrl.wb_sel;
    assign alu_op        = w_ctrl.alu_op;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign pc_source     = w_ctrl.pc_source;

    assign state       = r_state;
    assign halted      = (r_state == S_HALT);
    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;

`ifdef MC_CTRL_PERF_EN
    logic             w_count_cycle;
    logic             w_retire;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    assign w_count_cycle = (r_state != S_RESET) && (r_state != S_HALT) &&
                           (r_state != S_ERROR);

    // One pulse per instruction, on the cycle its retiring state exits
    assign w_retire = (r_state == S_MEM_WB) || (r_state == S_ALU_WB) ||
                      (r_state == S_BRANCH) || (r_state == S_JAL)    ||
                      (r_state == S_JALR)   || (r_state == S_LUI)    ||
                      ((r_state == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (w_count_cycle) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4). Each instruction
// is expanded into a list of expected cycles (state, mem_ready, halt_req)
// from the instruction-class rules; every cycle's outputs are compared.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        halt_req = 1'b0;
    logic        pc_write, pc_write_cond, branch_inv, iord;
    logic        mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  wb_sel, alu_op, alu_src_a, alu_src_b, pc_source;
    logic [3:0]  state;
    logic        halted, err_illegal, err_timeout;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
    int unsigned m_cyc = 0;
    int unsigned m_ret = 0;
`endif

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .halt_req      (halt_req),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_inv    (branch_inv),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .state         (state),
        .halted        (halted),
        .err_illegal   (err_illegal),
        .err_timeout   (err_timeout)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        state_e      st;
        logic        rdy;
        logic        hreq;
        logic [31:0] ins;
        logic        ei;
        logic        et;
    } step_t;

    step_t plan[$];

    logic [17:0] obs_ctrl;
    assign obs_ctrl = {pc_write, pc_write_cond, branch_inv, iord, mem_read, mem_write,
                       ir_write, reg_write, wb_sel, alu_op, alu_src_a, alu_src_b, pc_source};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Output table per state, straight from the control-signal listing
    function automatic logic [17:0] exp_ctrl(input state_e s, input logic [31:0] ins,
                                             input logic rdy);
        logic pcw, pcwc, binv, io, mrd, mwr, irw, rw;
        logic [1:0] wb, op, a, b, pcs;
        pcw = 0; pcwc = 0; binv = 0; io = 0; mrd = 0; mwr = 0; irw = 0; rw = 0;
        wb = 0; op = 0; a = 0; b = 0; pcs = 0;
        case (s)
            S_FETCH:   begin mrd = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:  begin a = 2'b10; b = 2'b10; end
            S_MEM_ADR: begin a = 2'b01; b = 2'b10; end
            S_MEM_RD:  begin io = 1; mrd = 1; end
            S_MEM_WB:  begin rw = 1; wb = 2'b01; end
            S_MEM_WR:  begin io = 1; mwr = 1; end
            S_EXEC_R:  begin a = 2'b01; b = 2'b00; op = 2'b10; end
            S_EXEC_I:  begin a = 2'b01; b = 2'b10; op = 2'b11; end
            S_ALU_WB:  begin rw = 1; wb = 2'b00; end
            S_BRANCH:  begin a = 2'b01; op = 2'b01; pcwc = 1; pcs = 2'b01; binv = ins[12]; end
            S_JAL:     begin pcw = 1; pcs = 2'b01; rw = 1; wb = 2'b10; end
            S_JALR:    begin a = 2'b01; b = 2'b10; pcw = 1; pcs = 2'b10; rw = 1; wb = 2'b10; end
            S_LUI:     begin rw = 1; wb = 2'b11; end
            default:   ;
        endcase
        return {pcw, pcwc, binv, io, mrd, mwr, irw, rw, wb, op, a, b, pcs};
    endfunction

    function automatic void push(input state_e st, input logic rdy, input logic hreq,
                                 input logic [31:0] ins, input logic ei, input logic et);
        step_t s;
        s.st = st; s.rdy = rdy; s.hreq = hreq; s.ins = ins; s.ei = ei; s.et = et;
        plan.push_back(s);
    endfunction

    function automatic logic [31:0] mk_instr(input int kind);
        logic [31:0] v;
        v = $urandom;
        case (kind)
            0: v[6:0] = 7'b0110011;
            1: v[6:0] = 7'b0010011;
            2: v[6:0] = 7'b0000011;
            3: v[6:0] = 7'b0100011;
            4: begin v[6:0] = 7'b1100011; v[14:12] = 3'b000; end
            5: begin v[6:0] = 7'b1100011; v[14:12] = 3'b001; end
            6: v[6:0] = 7'b1101111;
            7: v[6:0] = 7'b1100111;
            default: v[6:0] = 7'b0110111;
        endcase
        return v;
    endfunction

    // Expected cycle list for one instruction: fs fetch stalls, ms data stalls,
    // halt requested at the retiring cycle when halt_end is set.
    task automatic plan_instr(input logic [31:0] ins, input int fs, input int ms,
                              input logic halt_end);
        logic legal;
        legal = 1'b1;
        for (int i = 0; i < fs; i++) push(S_FETCH, 1'b0, rb(), ins, 0, 0);
        push(S_FETCH, 1'b1, rb(), ins, 0, 0);
        push(S_DECODE, rb(), rb(), ins, 0, 0);
        case (ins[6:0])
            7'b0000011: begin
                push(S_MEM_ADR, rb(), rb(), ins, 0, 0);
                for (int i = 0; i < ms; i++) push(S_MEM_RD, 1'b0, rb(), ins, 0, 0);
                push(S_MEM_RD, 1'b1, rb(), ins, 0, 0);
                push(S_MEM_WB, rb(), halt_end, ins, 0, 0);
            end
            7'b0100011: begin
                push(S_MEM_ADR, rb(), rb(), ins, 0, 0);
                for (int i = 0; i < ms; i++) push(S_MEM_WR, 1'b0, rb(), ins, 0, 0);
                push(S_MEM_WR, 1'b1, halt_end, ins, 0, 0);
            end
            7'b0110011: begin
                push(S_EXEC_R, rb(), halt_end | rb(), ins, 0, 0);
                push(S_ALU_WB, rb(), halt_end, ins, 0, 0);
            end
            7'b0010011: begin
                push(S_EXEC_I, rb(), halt_end | rb(), ins, 0, 0);
                push(S_ALU_WB, rb(), halt_end, ins, 0, 0);
            end
            7'b1100011: begin
                if (ins[14:13] == 2'b00) push(S_BRANCH, rb(), halt_end, ins, 0, 0);
                else legal = 1'b0;
            end
            7'b1101111: push(S_JAL, rb(), halt_end, ins, 0, 0);
            7'b1100111: push(S_JALR, rb(), halt_end, ins, 0, 0);
            7'b0110111: push(S_LUI, rb(), halt_end, ins, 0, 0);
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            for (int i = 0; i < 3; i++) push(S_ERROR, rb(), rb(), ins, 1'b1, 1'b0);
        end else if (halt_end) begin
            push(S_HALT, rb(), 1'b1, ins, 0, 0);
            push(S_HALT, rb(), 1'b1, ins, 0, 0);
            push(S_HALT, rb(), 1'b0, ins, 0, 0);
        end
    endtask

    task automatic run_plan();
        step_t s;
        logic  ret;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            instr = s.ins; mem_ready = s.rdy; halt_req = s.hreq;
            #1;
            chk("state", 32'(state), 32'(s.st));
            chk("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(s.st, s.ins, s.rdy)));
            chk("halted", 32'(halted), 32'(s.st == S_HALT));
            chk("err_illegal", 32'(err_illegal), 32'(s.ei));
            chk("err_timeout", 32'(err_timeout), 32'(s.et));
            ret = (s.st inside {S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI}) ||
                  (s.st == S_MEM_WR && s.rdy);
`ifdef MC_CTRL_PERF_EN
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("instret_cnt", instret_cnt, m_ret);
            if (!(s.st inside {S_RESET, S_HALT, S_ERROR})) m_cyc++;
            if (ret) m_ret++;
`else
            if (ret) n_total = n_total + 0;
`endif
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(S_RESET));
        chk({tag, "_ctrl"}, 32'(obs_ctrl), 32'd0);
        chk({tag, "_flags"}, 32'({halted, err_illegal, err_timeout}), 32'd0);
`ifdef MC_CTRL_PERF_EN
        chk({tag, "_perf"}, cycle_cnt | instret_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset(input logic hreq);
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1; halt_req = 1'b1;
        #1;
        chk_idle("reset_low");
        @(negedge clk);
        rst_n = 1'b1; halt_req = hreq; mem_ready = rb();
        #1;
        chk_idle("reset_rel");
`ifdef MC_CTRL_PERF_EN
        m_cyc = 0; m_ret = 0;
`endif
    endtask

    initial begin
        logic [31:0] ins;
        do_reset(1'b0);

        // add x3,x1,x2: FETCH, DECODE, EXEC_R, ALU_WB
        plan_instr(32'h002081B3, 0, 0, 1'b0); run_plan();
        // lw with 3 stall cycles in MEM_RD
        plan_instr(32'h00002183, 0, 3, 1'b0); run_plan();
        // bne
        plan_instr(mk_instr(5), 0, 0, 1'b0); run_plan();
        // jalr
        plan_instr(32'h000080E7, 0, 0, 1'b0); run_plan();
        // halt requested from EXEC_R through ALU_WB
        plan_instr(32'h002081B3, 0, 0, 1'b1); run_plan();
        // store completing on the last tolerated wait cycle
        plan_instr(32'h00202023, TO - 1, TO - 1, 1'b0); run_plan();

        for (int n = 0; n < 40; n++) begin
            plan_instr(mk_instr($urandom_range(0, 8)), $urandom_range(0, TO - 1),
                       $urandom_range(0, TO - 1), ($urandom_range(0, 3) == 0));
            run_plan();
        end

        // Reset straight into HALT
        do_reset(1'b1);
        push(S_HALT, rb(), 1'b1, 32'h0, 0, 0);
        push(S_HALT, rb(), 1'b0, 32'h0, 0, 0);
        plan_instr(32'h123450B7, 1, 0, 1'b0); run_plan();

        // Illegal opcode, then unsupported branch funct3
        plan_instr(32'h0000007F, 0, 0, 1'b0); run_plan();
        do_reset(1'b0);
        plan_instr(32'h00002063, 0, 0, 1'b0); run_plan();
        do_reset(1'b0);

        // Store timeout: 4 stalled cycles in MEM_WR
        ins = 32'h00202023;
        push(S_FETCH, 1'b1, 1'b0, ins, 0, 0);
        push(S_DECODE, rb(), rb(), ins, 0, 0);
        push(S_MEM_ADR, rb(), rb(), ins, 0, 0);
        for (int i = 0; i < TO; i++) push(S_MEM_WR, 1'b0, rb(), ins, 0, 0);
        for (int i = 0; i < 3; i++) push(S_ERROR, rb(), rb(), ins, 1'b0, 1'b1);
        run_plan();
        do_reset(1'b0);

        // Fetch timeout
        for (int i = 0; i < TO; i++) push(S_FETCH, 1'b0, rb(), ins, 0, 0);
        for (int i = 0; i < 2; i++) push(S_ERROR, rb(), rb(), ins, 1'b0, 1'b1);
        run_plan();
        do_reset(1'b0);

        // Asynchronous reset in the middle of a store
        plan_instr(32'h00202023, 0, 2, 1'b0);
        void'(plan.pop_back());
        run_plan();
        #1 rst_n = 1'b0;
        #1;
        chk("async_mem_write", 32'(mem_write), 32'd0);
        chk_idle("async");
        do_reset(1'b0);
        plan_instr(32'h002081B3, 0, 0, 1'b0); run_plan();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
